// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer: state encodings,
// opcode and ALU constants, IR field positions and the control strobe bundle.
package cpu_ctrl_pkg;

    localparam int unsigned STATE_W   = 4;
    localparam int unsigned OPC_W     = 5;
    localparam int unsigned IR_OPC_HI = 31;
    localparam int unsigned IR_OPC_LO = 27;

    typedef enum logic [STATE_W-1:0] {
        StReset  = 4'd0,
        StF0     = 4'd1,
        StF1     = 4'd2,
        StF2     = 4'd3,
        StT3     = 4'd4,
        StT4     = 4'd5,
        StT5     = 4'd6,
        StT6     = 4'd7,
        StT7     = 4'd8,
        StHalted = 4'd9
    } state_e;

    localparam logic [OPC_W-1:0] OpLd   = 5'b00000;
    localparam logic [OPC_W-1:0] OpLdi  = 5'b00001;
    localparam logic [OPC_W-1:0] OpSt   = 5'b00010;
    localparam logic [OPC_W-1:0] OpAdd  = 5'b00011;
    localparam logic [OPC_W-1:0] OpSub  = 5'b00100;
    localparam logic [OPC_W-1:0] OpAnd  = 5'b00101;
    localparam logic [OPC_W-1:0] OpOr   = 5'b00110;
    localparam logic [OPC_W-1:0] OpNop  = 5'b11010;
    localparam logic [OPC_W-1:0] OpHalt = 5'b11011;

    localparam logic [4:0] AluAdd = 5'b00000;
    localparam logic [4:0] AluSub = 5'b00001;
    localparam logic [4:0] AluAnd = 5'b00010;
    localparam logic [4:0] AluOr  = 5'b00011;

    typedef struct packed {
        logic       pc_increment_enable;
        logic       ir_enable;
        logic       y_enable;
        logic       z_enable;
        logic       mar_enable;
        logic       mdr_enable;
        logic       r_enable;
        logic       read;
        logic       write;
        logic       gra;
        logic       grb;
        logic       grc;
        logic       ba_select;
        logic       rout;
        logic       pc_select;
        logic       z_lo_select;
        logic       mdr_select;
        logic       c_select;
        logic [4:0] alu_instruction;
        logic       run;
        logic       illegal_op;
    } ctrl_t;

    // Register-register ALU instructions (add/sub/and/or)
    function automatic logic is_alu_op(input logic [OPC_W-1:0] opc);
        return (opc == OpAdd) || (opc == OpSub) || (opc == OpAnd) || (opc == OpOr);
    endfunction

    // Memory-addressed instructions sharing the Rb+C address computation
    function automatic logic is_mem_op(input logic [OPC_W-1:0] opc);
        return (opc == OpLd) || (opc == OpLdi) || (opc == OpSt);
    endfunction

    function automatic logic is_defined_op(input logic [OPC_W-1:0] opc);
        return is_alu_op(opc) || is_mem_op(opc) || (opc == OpNop) || (opc == OpHalt);
    endfunction

    function automatic logic [4:0] alu_code(input logic [OPC_W-1:0] opc);
        logic [4:0] code;
        case (opc)
            OpSub:   code = AluSub;
            OpAnd:   code = AluAnd;
            OpOr:    code = AluOr;
            default: code = AluAdd;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational map from (present state, opcode) to the control strobe bundle.
module ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  state_e           state,
    input  logic [OPC_W-1:0] opcode,
    output ctrl_t            ctrl
);

    // Moore decode: every strobe defaults low, run defaults high
    always_comb begin
        ctrl     = '0;
        ctrl.run = 1'b1;
        unique case (state)
            StReset: ;
            StF0: begin
                ctrl.pc_select  = 1'b1;
                ctrl.mar_enable = 1'b1;
            end
            StF1: begin
                ctrl.pc_increment_enable = 1'b1;
                ctrl.read                = 1'b1;
                ctrl.mdr_enable          = 1'b1;
            end
            StF2: begin
                ctrl.mdr_select = 1'b1;
                ctrl.ir_enable  = 1'b1;
            end
            StT3: begin
                if (is_mem_op(opcode)) begin
                    ctrl.grb       = 1'b1;
                    ctrl.ba_select = 1'b1;
                    ctrl.y_enable  = 1'b1;
                end else if (is_alu_op(opcode)) begin
                    ctrl.grb      = 1'b1;
                    ctrl.rout     = 1'b1;
                    ctrl.y_enable = 1'b1;
                end else if (!is_defined_op(opcode)) begin
                    ctrl.illegal_op = 1'b1;
                end
            end
            StT4: begin
                if (is_mem_op(opcode)) begin
                    ctrl.c_select        = 1'b1;
                    ctrl.alu_instruction = AluAdd;
                    ctrl.z_enable        = 1'b1;
                end else if (is_alu_op(opcode)) begin
                    ctrl.grc             = 1'b1;
                    ctrl.rout            = 1'b1;
                    ctrl.alu_instruction = alu_code(opcode);
                    ctrl.z_enable        = 1'b1;
                end
            end
            StT5: begin
                if (opcode == OpLd || opcode == OpSt) begin
                    ctrl.z_lo_select = 1'b1;
                    ctrl.mar_enable  = 1'b1;
                end else if (opcode == OpLdi || is_alu_op(opcode)) begin
                    ctrl.z_lo_select = 1'b1;
                    ctrl.gra         = 1'b1;
                    ctrl.r_enable    = 1'b1;
                end
            end
            StT6: begin
                if (opcode == OpLd) begin
                    ctrl.read       = 1'b1;
                    ctrl.mdr_enable = 1'b1;
                end else if (opcode == OpSt) begin
                    // read stays low so MDR captures Ra from the bus
                    ctrl.gra        = 1'b1;
                    ctrl.rout       = 1'b1;
                    ctrl.mdr_enable = 1'b1;
                end
            end
            StT7: begin
                if (opcode == OpLd) begin
                    ctrl.mdr_select = 1'b1;
                    ctrl.gra        = 1'b1;
                    ctrl.r_enable   = 1'b1;
                end else if (opcode == OpSt) begin
                    ctrl.write = 1'b1;
                end
            end
            StHalted: begin
                ctrl.run = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired control sequencer: state register plus next-state logic; strobes
// are decoded from present state and the IR opcode by ctrl_decode.
module control_unit
    import cpu_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         IR_Data,
    output logic                PC_enable,
    output logic                PC_increment_enable,
    output logic                IR_enable,
    output logic                Y_enable,
    output logic                Z_enable,
    output logic                MAR_enable,
    output logic                MDR_enable,
    output logic                r_enable,
    output logic                read,
    output logic                write,
    output logic                Gra,
    output logic                Grb,
    output logic                Grc,
    output logic                ba_select,
    output logic                Rout,
    output logic                PC_select,
    output logic                Z_LO_select,
    output logic                MDR_select,
    output logic                c_select,
    output logic [4:0]          alu_instruction,
    output logic                run,
    output logic                illegal_op,
    output logic [STATE_W-1:0]  present_state
);

    state_e           state_q;
    state_e           state_d;
    logic [OPC_W-1:0] opcode;
    ctrl_t            ctrl;
    logic             unused_ir;

    assign opcode    = IR_Data[IR_OPC_HI:IR_OPC_LO];
    assign unused_ir = ^IR_Data[IR_OPC_LO-1:0];

    // State register with synchronous reset that overrides any state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StReset;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: shared fetch, then branch on opcode at T3 and T5
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StReset: state_d = StF0;
            StF0:    state_d = StF1;
            StF1:    state_d = StF2;
            StF2:    state_d = StT3;
            StT3: begin
                if (opcode == OpHalt) begin
                    state_d = StHalted;
                end else if (is_mem_op(opcode) || is_alu_op(opcode)) begin
                    state_d = StT4;
                end else begin
                    state_d = StF0;
                end
            end
            StT4:    state_d = StT5;
            StT5: begin
                if (opcode == OpLd || opcode == OpSt) begin
                    state_d = StT6;
                end else begin
                    state_d = StF0;
                end
            end
            StT6:     state_d = StT7;
            StT7:     state_d = StF0;
            StHalted: state_d = StHalted;
            default:  state_d = StReset;
        endcase
    end

    ctrl_decode u_ctrl_decode (
        .state  (state_q),
        .opcode (opcode),
        .ctrl   (ctrl)
    );

    assign PC_enable           = 1'b0;
    assign PC_increment_enable = ctrl.pc_increment_enable;
    assign IR_enable           = ctrl.ir_enable;
    assign Y_enable            = ctrl.y_enable;
    assign Z_enable            = ctrl.z_enable;
    assign MAR_enable          = ctrl.mar_enable;
    assign MDR_enable          = ctrl.mdr_enable;
    assign r_enable            = ctrl.r_enable;
    assign read                = ctrl.read;
    assign write               = ctrl.write;
    assign Gra                 = ctrl.gra;
    assign Grb                 = ctrl.grb;
    assign Grc                 = ctrl.grc;
    assign ba_select           = ctrl.ba_select;
    assign Rout                = ctrl.rout;
    assign PC_select           = ctrl.pc_select;
    assign Z_LO_select         = ctrl.z_lo_select;
    assign MDR_select          = ctrl.mdr_select;
    assign c_select            = ctrl.c_select;
    assign alu_instruction     = ctrl.alu_instruction;
    assign run                 = ctrl.run;
    assign illegal_op          = ctrl.illegal_op;
    assign present_state       = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: per-instruction microstep tables drive
// the expected strobes cycle by cycle for directed and random instruction streams.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] IR_Data;
    logic PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable;
    logic MAR_enable, MDR_enable, r_enable, read, write;
    logic Gra, Grb, Grc, ba_select, Rout;
    logic PC_select, Z_LO_select, MDR_select, c_select;
    logic [4:0] alu_instruction;
    logic run, illegal_op;
    logic [3:0] present_state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    control_unit dut (
        .clk                 (clk),
        .reset               (reset),
        .IR_Data             (IR_Data),
        .PC_enable           (PC_enable),
        .PC_increment_enable (PC_increment_enable),
        .IR_enable           (IR_enable),
        .Y_enable            (Y_enable),
        .Z_enable            (Z_enable),
        .MAR_enable          (MAR_enable),
        .MDR_enable          (MDR_enable),
        .r_enable            (r_enable),
        .read                (read),
        .write               (write),
        .Gra                 (Gra),
        .Grb                 (Grb),
        .Grc                 (Grc),
        .ba_select           (ba_select),
        .Rout                (Rout),
        .PC_select           (PC_select),
        .Z_LO_select         (Z_LO_select),
        .MDR_select          (MDR_select),
        .c_select            (c_select),
        .alu_instruction     (alu_instruction),
        .run                 (run),
        .illegal_op          (illegal_op),
        .present_state       (present_state)
    );

    // Bit positions of each strobe in the observed vector
    localparam int PCI = 17, IRE = 16, YE = 15, ZE = 14, MARE = 13, MDRE = 12;
    localparam int REN = 11, RD = 10, WR = 9, GA = 8, GB = 7, GC = 6;
    localparam int BA = 5, RO = 4, PCS = 3, ZLO = 2, MDS = 1, CS = 0;

    logic [17:0] strobes;
    assign strobes = {PC_increment_enable, IR_enable, Y_enable, Z_enable, MAR_enable,
                      MDR_enable, r_enable, read, write, Gra, Grb, Grc, ba_select, Rout,
                      PC_select, Z_LO_select, MDR_select, c_select};

    function automatic logic [17:0] b(input int i);
        return 18'd1 << i;
    endfunction

    // Cycles an instruction occupies from F0 back to F0
    function automatic int instr_len(input logic [4:0] opc);
        if (opc == 5'd0 || opc == 5'd2) return 8;
        if (opc >= 5'd1 && opc <= 5'd6) return 6;
        return 4;
    endfunction

    // Expected strobes, ALU code and illegal flag for cycle k of an instruction
    function automatic void model(input logic [4:0] opc, input int k,
                                  output logic [17:0] s, output logic [4:0] alu,
                                  output logic ill);
        bit is_mem = (opc <= 5'd2);
        bit is_alu = (opc >= 5'd3 && opc <= 5'd6);
        s   = '0;
        alu = 5'd0;
        ill = 1'b0;
        case (k)
            0: s = b(PCS) | b(MARE);
            1: s = b(PCI) | b(RD) | b(MDRE);
            2: s = b(MDS) | b(IRE);
            3: begin
                if (is_mem) s = b(GB) | b(BA) | b(YE);
                else if (is_alu) s = b(GB) | b(RO) | b(YE);
                else ill = !(opc == 5'd26 || opc == 5'd27);
            end
            4: begin
                if (is_mem) s = b(CS) | b(ZE);
                else if (is_alu) begin
                    s   = b(GC) | b(RO) | b(ZE);
                    alu = opc - 5'd3;
                end
            end
            5: begin
                if (opc == 5'd1 || is_alu) s = b(ZLO) | b(GA) | b(REN);
                else if (is_mem) s = b(ZLO) | b(MARE);
            end
            6: begin
                if (opc == 5'd0) s = b(RD) | b(MDRE);
                else if (opc == 5'd2) s = b(GA) | b(RO) | b(MDRE);
            end
            7: begin
                if (opc == 5'd0) s = b(MDS) | b(GA) | b(REN);
                else if (opc == 5'd2) s = b(WR);
            end
            default: ;
        endcase
    endfunction

    // Compare one cycle of outputs against the model plus global invariants
    task automatic check_cycle(input logic [4:0] opc, input int k, input string tag);
        logic [17:0] es;
        logic [4:0]  ea;
        logic        ei;
        model(opc, k, es, ea, ei);
        total++;
        if (present_state !== 4'(k + 1)) begin
            bad++;
            $display("FAIL %s state k=%0d: got %0d want %0d", tag, k, present_state, k + 1);
        end
        total++;
        if (strobes !== es) begin
            bad++;
            $display("FAIL %s strobes k=%0d: got %b want %b", tag, k, strobes, es);
        end
        total++;
        if (alu_instruction !== ea) begin
            bad++;
            $display("FAIL %s alu k=%0d: got %b want %b", tag, k, alu_instruction, ea);
        end
        total++;
        if (illegal_op !== ei || run !== 1'b1 || PC_enable !== 1'b0) begin
            bad++;
            $display("FAIL %s ill/run/pce k=%0d: got %b%b%b want %b10", tag, k,
                     illegal_op, run, PC_enable, ei);
        end
        total++;
        if ($countones({Rout, PC_select, Z_LO_select, MDR_select, c_select}) > 1 ||
            (read && write)) begin
            bad++;
            $display("FAIL %s bus/rw conflict k=%0d: got %b", tag, k, strobes);
        end
    endtask

    // Expects to be called at F0; runs a whole instruction and checks the return
    task automatic run_instr(input logic [31:0] ir, input string tag);
        logic [4:0] opc = ir[31:27];
        IR_Data = ir;
        for (int k = 0; k < instr_len(opc); k++) begin
            check_cycle(opc, k, tag);
            @(posedge clk); #1;
        end
        total++;
        if (present_state !== 4'd1) begin
            bad++;
            $display("FAIL %s return to F0: got %0d want 1", tag, present_state);
        end
    endtask

    task automatic check_idle(input string tag, input logic [3:0] st, input logic er);
        total++;
        if (present_state !== st || strobes !== 18'd0 || alu_instruction !== 5'd0 ||
            illegal_op !== 1'b0 || run !== er) begin
            bad++;
            $display("FAIL %s: got st=%0d s=%b alu=%b ill=%b run=%b want st=%0d s=0 run=%b",
                     tag, present_state, strobes, alu_instruction, illegal_op, run, st, er);
        end
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        IR_Data = 32'h0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_idle("reset_state", 4'd0, 1'b1);
        reset = 1'b0;
        @(posedge clk); #1;
        total++;
        if (present_state !== 4'd1) begin
            bad++;
            $display("FAIL reset_to_f0: got %0d want 1", present_state);
        end
    endtask

    task automatic test_directed();
        run_instr(32'h00880055, "ld");
        run_instr(32'h08880055, "ldi");
        run_instr(32'h10880055, "st");
        run_instr(32'h18918000, "add");
        run_instr(32'h20918000, "sub");
        run_instr(32'h28918000, "and");
        run_instr(32'h30918000, "or");
        run_instr(32'hD0000000, "nop");
        run_instr(32'hF8000000, "undef");
    endtask

    task automatic test_back_to_back();
        logic [4:0] opc;
        for (int n = 0; n < 60; n++) begin
            int sel = int'($urandom_range(0, 8));
            if (sel <= 6) opc = 5'(sel);
            else if (sel == 7) opc = 5'd26;
            else begin
                do opc = 5'($urandom_range(7, 31)); while (opc == 5'd26 || opc == 5'd27);
            end
            run_instr({opc, 27'($urandom)}, "random");
        end
    endtask

    task automatic test_halt();
        IR_Data = 32'hD8000000;
        for (int k = 0; k < 4; k++) begin
            check_cycle(5'd27, k, "halt_fetch");
            @(posedge clk); #1;
        end
        for (int n = 0; n < 20; n++) begin
            check_idle("halted", 4'd9, 1'b0);
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_idle("halt_reset", 4'd0, 1'b1);
        @(posedge clk); #1;
        total++;
        if (present_state !== 4'd1 || run !== 1'b1) begin
            bad++;
            $display("FAIL halt_reset_f0: got st=%0d run=%b want st=1 run=1",
                     present_state, run);
        end
    endtask

    task automatic test_reset_mid();
        IR_Data = 32'h00880055;
        for (int k = 0; k <= 5; k++) begin
            check_cycle(5'd0, k, "mid_ld");
            if (k < 5) begin
                @(posedge clk); #1;
            end
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_idle("mid_reset", 4'd0, 1'b1);
        @(posedge clk); #1;
        total++;
        if (present_state !== 4'd1) begin
            bad++;
            $display("FAIL mid_reset_f0: got %0d want 1", present_state);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_halt();
        test_reset_mid();
        run_instr(32'h00880055, "ld_after_reset");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Hardwired control sequencer that generates every datapath control strobe per clock: fetch T0–T2, then execute T3–T7.
- Sits directly upstream of `datapath`. Consumes the instruction register contents and drives the enable, select, read/write, Gra/Grb/Grc and ALU-opcode inputs that were hand-sequenced in bench-driven bring-up.
- Supports ld, ldi, st, add, sub, and, or, nop and halt.
- Moore-style: one state per clock cycle. Outputs decode from present state plus the IR opcode, which is stable from T3 on.

Parameters:
- STATE_W, 4, width of present_state.
- OPC_W, 5, opcode width (IR_Data[31:27]).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high; sampled on rising clk.
- IR_Data  in  32  instruction register contents; only [31:27] used.
- PC_enable  out  1  unused by this instruction set; tied 0.
- PC_increment_enable  out  1  PC <= PC+1.
- IR_enable  out  1  load IR.
- Y_enable, Z_enable  out  1 each  load Y / load Z.
- MAR_enable, MDR_enable  out  1 each  load MAR / load MDR.
- r_enable  out  1  register-file write.
- read  out  1  MDR mux selects memory data; also the memory read strobe.
- write  out  1  memory write strobe.
- Gra, Grb, Grc, ba_select, Rout  out  1 each  select/encode controls.
- PC_select, Z_LO_select, MDR_select, c_select  out  1 each  bus-encoder sources.
- alu_instruction  out  5  ALU op code.
- run  out  1  high except in HALTED.
- illegal_op  out  1  one-cycle pulse in T3 on an undefined opcode.
- present_state  out  4  debug view of the state register.

Behaviour:
- States: RESET=0, F0=1, F1=2, F2=3, T3=4, T4=5, T5=6, T6=7, T7=8, HALTED=9.
- reset high at a rising edge: state <= RESET regardless of current state, including mid-instruction and from HALTED.
- In RESET, all strobes are 0, alu_instruction=0 and run=1. RESET → F0 unconditionally.
- Any signal not listed for a state is 0 in that state.
- Fetch sequence, shared by all instructions:
  - F0: PC_select, MAR_enable.
  - F1: PC_increment_enable, read, MDR_enable.
  - F2: MDR_select, IR_enable.
  - Then → T3.
- ld (opcode 00000):
  - T3: Grb, ba_select, Y_enable.
  - T4: c_select, alu_instruction=ADD, Z_enable.
  - T5: Z_LO_select, MAR_enable.
  - T6: read, MDR_enable.
  - T7: MDR_select, Gra, r_enable; then → F0.
  - Total 8 cycles.
- ldi (00001): T3 and T4 as ld. T5: Z_LO_select, Gra, r_enable; then → F0. Total 6 cycles.
- st (00010):
  - T3–T5 as ld.
  - T6: Gra, Rout, MDR_enable, with read=0 so MDR takes the bus.
  - T7: write; then → F0.
- add/sub/and/or (00011/00100/00101/00110):
  - T3: Grb, Rout, Y_enable.
  - T4: Grc, Rout, alu_instruction=op, Z_enable.
  - T5: Z_LO_select, Gra, r_enable; then → F0.
- nop (11010): T3 asserts nothing, then → F0 (4 cycles).
- halt (11011): T3 → HALTED. In HALTED, all strobes are 0 and run=0; it stays there until reset.
- Undefined opcode: behaves as nop, with illegal_op=1 for the T3 cycle only.
- ALU codes: ADD=00000, SUB=00001, AND=00010, OR=00011.
- The opcode is read combinationally from IR_Data in T3–T7. IR is written only in F2, so it is stable there. The opcode is never sampled in F0–F2.
- Never assert two bus-source selects in the same cycle: PC_select, Z_LO_select, MDR_select, c_select, Rout.
- Never assert read and write together.

Decomposition:
- Package `cpu_ctrl_pkg` holds: state encodings, opcode constants, ALU op constants, and IR field bit positions.
- Natural single sub-module: `ctrl_decode`, a purely combinational map from (state, opcode) to the output strobe bundle. The top level holds only the state register and next-state logic.

Test Plan:
- Reset then IR=0x00880055 (ld): present_state sequence 0,1,2,3,4,5,6,7,8,1. In T4, alu_instruction=0 and Z_enable=1. In T7, MDR_select=Gra=r_enable=1. No other strobes anywhere.
- IR=0x08880055 (ldi): T5 asserts Z_LO_select, Gra, r_enable; state returns to F0 after exactly 6 cycles.
- IR=0x10880055 (st): T6 has Rout=Gra=MDR_enable=1 with read=0; T7 has write=1 alone; read never coincides with write.
- IR=0x20918000 (sub): T4 has alu_instruction=00001, Grc=1, Rout=1; T5 has r_enable=1. Repeat with and=00010 and or=00011.
- IR=0xF8000000 (undefined 11111): illegal_op=1 for one cycle in T3, then F0. Next, IR=0xD8000000 (halt): state=9, run=0, held for 20 cycles.
- Reset asserted during ld T5: the next state is RESET with all strobes 0. A reset pulse in HALTED returns to RESET/F0 with run=1.
